boot_rom_ctrl: RTL

// - Parametrised on-chip boot ROM on the Ibex-style req/gnt/rvalid bus; replaces the fixed 64-word hard-coded ROM.
// - Contents come from a hex image. Depth, base address and read latency are configurable.
// - Out-of-map accesses complete with an error instead of hanging the core.
// - Optional second read port lets the data bus fetch .rodata from the ROM.

---
 rtl/boot_rom_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/boot_rom_ctrl.sv
// Parametrised boot ROM on a req/gnt/rvalid bus, image supplied as a packed parameter.
// Define BOOTROM_DPORT_EN to enable the round-robin arbitrated data read port.
module boot_rom_ctrl #(
  parameter int unsigned           DEPTH      = 256,
  parameter logic [31:0]           BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned           LATENCY    = 1,
  parameter logic [DEPTH*32-1:0]   INIT_IMAGE = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  typedef struct packed {
    logic        valid;
    port_e       port;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef logic [DEPTH-1:0][31:0] rom_t;

  // Words not supplied in the image read zero.
  localparam rom_t ROM = rom_t'(INIT_IMAGE);

  logic        instr_win;
  logic        grant;
  logic        sel_we;
  port_e       sel_port;
  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic        hit;
  resp_t       req_resp;
  resp_t       last_stage;

`ifdef BOOTROM_DPORT_EN
  logic  data_win;
  port_e last_grant;

  // Round-robin: on contention the port not granted last time wins.
  assign instr_win = instr_req_i && (!data_req_i || last_grant == PORT_D);
  assign data_win  = data_req_i && !instr_win;
  assign grant     = instr_win || data_win;
  assign sel_port  = data_win ? PORT_D : PORT_I;
  assign sel_addr  = data_win ? data_addr_i : instr_addr_i;
  assign sel_we    = data_win && data_we_i;
  assign data_gnt_o = rst && data_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_D;
    end else if (instr_win) begin
      last_grant <= PORT_I;
    end else if (data_win) begin
      last_grant <= PORT_D;
    end
  end
`else
  logic unused_dport;

  assign instr_win    = instr_req_i;
  assign grant        = instr_req_i;
  assign sel_port     = PORT_I;
  assign sel_addr     = instr_addr_i;
  assign sel_we       = 1'b0;
  assign data_gnt_o   = 1'b0;
  assign unused_dport = ^{data_req_i, data_we_i, data_addr_i};
`endif

  assign instr_gnt_o = rst && instr_win;

  // Unsigned wrap makes addresses below the base decode as misses too.
  assign offset = sel_addr - BASE_ADDR;
  assign hit    = offset < SPAN;

  always_comb begin
    req_resp = '0;
    if (grant) begin
      req_resp.valid = 1'b1;
      req_resp.port  = sel_port;
      req_resp.err   = !hit || sel_we;
      if (hit && !sel_we) req_resp.rdata = ROM[offset[IDX_W+1:2]];
    end
  end

  // LATENCY-1 carry stages; the output registers supply the final cycle.
  if (LATENCY > 1) begin : g_pipe
    resp_t pipe [LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= req_resp;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign last_stage = pipe[LATENCY-2];
  end else begin : g_direct
    assign last_stage = req_resp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_rvalid_o <= 1'b0;
      instr_err_o    <= 1'b0;
      instr_rdata_o  <= 32'h0;
    end else begin
      instr_rvalid_o <= last_stage.valid && (last_stage.port == PORT_I);
      instr_err_o    <= last_stage.err && (last_stage.port == PORT_I);
      instr_rdata_o  <= (last_stage.port == PORT_I) ? last_stage.rdata : 32'h0;
    end
  end

`ifdef BOOTROM_DPORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= 32'h0;
    end else begin
      data_rvalid_o <= last_stage.valid && (last_stage.port == PORT_D);
      data_err_o    <= last_stage.err && (last_stage.port == PORT_D);
      data_rdata_o  <= (last_stage.port == PORT_D) ? last_stage.rdata : 32'h0;
    end
  end
`else
  assign data_rvalid_o = 1'b0;
  assign data_err_o    = 1'b0;
  assign data_rdata_o  = 32'h0;
`endif

  assign instr_rdata_intg_o = 7'b0;
  assign data_rdata_intg_o  = 7'b0;

endmodule
